proc_run_ctrl: RTL and testbench



---
 rtl/proc_run_ctrl.sv | 125 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Run/done sequencer: debounced start key, processor run enable, cycle counter
// and watchdog timeout, with state exported for LED/HEX display.
module proc_run_ctrl #(
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_key_n,
  input  logic        done,
  output logic        run,
  output logic        busy,
  output logic        complete,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TO_MAX  = 32'(TIMEOUT_CYCLES);

  logic             sync1_reg, sync2_reg;
  logic             key_stable_reg, key_stable_d_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             press_evt_reg;

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic        complete_reg, complete_next;
  logic        timeout_reg, timeout_next;

  // Key path: synchronizer, mismatch-count debouncer, registered falling-edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg        <= 1'b1;
      sync2_reg        <= 1'b1;
      key_stable_reg   <= 1'b1;
      key_stable_d_reg <= 1'b1;
      deb_cnt_reg      <= '0;
      press_evt_reg    <= 1'b0;
    end else begin
      sync1_reg <= start_key_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == key_stable_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        // This edge is the DEB_CYCLES-th consecutive mismatch.
        key_stable_reg <= sync2_reg;
        deb_cnt_reg    <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
      key_stable_d_reg <= key_stable_reg;
      press_evt_reg    <= key_stable_d_reg & ~key_stable_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      complete_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      complete_reg <= complete_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    complete_next = complete_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (press_evt_reg) begin
          count_next    = '0;
          complete_next = 1'b0;
          timeout_next  = 1'b0;
          state_next    = RUN;
        end
      end
      RUN: begin
        // done beats the watchdog when both land on the same cycle.
        if (done) begin
          complete_next = 1'b1;
          state_next    = DRAIN;
        end else if (count_reg == TO_LAST) begin
          count_next   = TO_MAX;
          timeout_next = 1'b1;
          state_next   = FAULT;
        end else begin
          count_next = count_reg + 32'd1;
        end
      end
      DRAIN: begin
        if (!done) state_next = IDLE;
      end
      FAULT: begin
        if (press_evt_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign run         = (state_reg == RUN);
  assign busy        = (state_reg == RUN);
  assign complete    = complete_reg;
  assign timeout     = timeout_reg;
  assign cycle_count = count_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with DEB_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_proc_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_key_n = 1'b1;
  logic        done = 1'b0;
  logic        run, busy, complete, timeout;
  logic [31:0] cycle_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int run_rises = 0;

  proc_run_ctrl #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start_key_n(start_key_n), .done(done),
    .run(run), .busy(busy), .complete(complete), .timeout(timeout),
    .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge run) run_rises++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounce-free press held for DEB_CYCLES+4 edges, then released.
  task automatic press();
    start_key_n = 1'b0;
    repeat (8) tick();
    start_key_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({run, busy, complete, timeout, state} !== 6'b0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: run=%0b busy=%0b complete=%0b timeout=%0b state=%0d count=%0d, expected all 0",
               run, busy, complete, timeout, state, cycle_count);
    end
    reset = 1'b0;
    repeat (2) tick();
    $display("reset: state=%0d run=%0b", state, run);
  endtask

  task automatic test_clean_run();
    start_key_n = 1'b0;
    repeat (7) tick();
    checks++;
    if (run !== 1'b0) begin
      errors++; $display("FAIL clean_early_run: run=%0b after 7 edges, expected 0", run);
    end
    tick();
    checks++;
    if (run !== 1'b1 || busy !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL clean_start_latency: run=%0b busy=%0b state=%0d after 8 edges, expected 1/1/1", run, busy, state);
    end
    start_key_n = 1'b1;
    repeat (37) tick();
    checks++;
    if (cycle_count !== 32'd37 || state !== 2'd1) begin
      errors++; $display("FAIL clean_count: count=%0d state=%0d, expected 37/1", cycle_count, state);
    end
    done = 1'b1;
    tick();
    checks++;
    if (run !== 1'b0 || state !== 2'd2 || complete !== 1'b1 || cycle_count !== 32'd37) begin
      errors++; $display("FAIL clean_done: run=%0b state=%0d complete=%0b count=%0d, expected 0/2/1/37", run, state, complete, cycle_count);
    end
    repeat (4) tick();
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL clean_drain_hold: state=%0d, expected 2", state);
    end
    done = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || complete !== 1'b1 || cycle_count !== 32'd37) begin
      errors++; $display("FAIL clean_idle: state=%0d complete=%0b count=%0d, expected 0/1/37", state, complete, cycle_count);
    end
    $display("clean_run: count=%0d complete=%0b", cycle_count, complete);
  endtask

  task automatic test_bounce();
    int r0;
    r0 = run_rises;
    for (int s = 0; s < 10; s++) begin
      start_key_n = (s % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    checks++;
    if (state !== 2'd0 || run_rises !== r0) begin
      errors++; $display("FAIL bounce_no_event: state=%0d rises=%0d, expected 0/%0d", state, run_rises, r0);
    end
    start_key_n = 1'b0;
    repeat (12) tick();
    checks++;
    if (run_rises !== r0 + 1 || state !== 2'd1) begin
      errors++; $display("FAIL bounce_one_run: rises=%0d state=%0d, expected %0d/1", run_rises, state, r0 + 1);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    start_key_n = 1'b1;
    repeat (10) tick();
    $display("bounce: run rises=%0d", run_rises - r0);
  endtask

  task automatic test_timeout();
    press();
    repeat (99) tick();
    checks++;
    if (cycle_count !== 32'd99 || state !== 2'd1) begin
      errors++; $display("FAIL timeout_pre: count=%0d state=%0d, expected 99/1", cycle_count, state);
    end
    tick();
    checks++;
    if (run !== 1'b0 || timeout !== 1'b1 || cycle_count !== 32'd100 || state !== 2'd3 || complete !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: run=%0b timeout=%0b count=%0d state=%0d complete=%0b, expected 0/1/100/3/0",
                        run, timeout, cycle_count, state, complete);
    end
    repeat (10) tick();
    press();
    checks++;
    if (state !== 2'd0 || run !== 1'b0 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_to_idle: state=%0d run=%0b timeout=%0b, expected 0/0/1", state, run, timeout);
    end
    repeat (10) tick();
    press();
    checks++;
    if (state !== 2'd1 || timeout !== 1'b0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL timeout_restart: state=%0d timeout=%0b count=%0d, expected 1/0/0", state, timeout, cycle_count);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    repeat (10) tick();
    $display("timeout: recovered state=%0d", state);
  endtask

  task automatic test_stale_done();
    int r0;
    done = 1'b1;
    repeat (3) tick();
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL stale_idle: state=%0d, expected 0", state);
    end
    press();
    r0 = run_rises;
    tick();
    checks++;
    if (state !== 2'd2 || cycle_count !== 32'd0 || complete !== 1'b1) begin
      errors++; $display("FAIL stale_one_cycle: state=%0d count=%0d complete=%0b, expected 2/0/1", state, cycle_count, complete);
    end
    repeat (5) tick();
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL stale_drain: state=%0d, expected 2", state);
    end
    done = 1'b0;
    repeat (20) tick();
    checks++;
    if (state !== 2'd0 || run_rises !== r0) begin
      errors++; $display("FAIL stale_no_rerun: state=%0d rises=%0d, expected 0/%0d", state, run_rises, r0);
    end
    $display("stale_done: state=%0d", state);
  endtask

  task automatic test_back_to_back();
    press();
    repeat (10) tick();
    press();
    checks++;
    if (state !== 2'd1 || cycle_count !== 32'd18) begin
      errors++; $display("FAIL midrun_press: state=%0d count=%0d, expected 1/18", state, cycle_count);
    end
    done = 1'b1;
    tick();
    checks++;
    if (state !== 2'd2 || cycle_count !== 32'd18 || complete !== 1'b1) begin
      errors++; $display("FAIL midrun_done: state=%0d count=%0d complete=%0b, expected 2/18/1", state, cycle_count, complete);
    end
    done = 1'b0;
    repeat (10) tick();
    press();
    repeat (99) tick();
    done = 1'b1;
    tick();
    checks++;
    if (complete !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd99 || state !== 2'd2) begin
      errors++; $display("FAIL tie: complete=%0b timeout=%0b count=%0d state=%0d, expected 1/0/99/2",
                        complete, timeout, cycle_count, state);
    end
    done = 1'b0;
    repeat (10) tick();
    $display("back_to_back: tie count=99 checked, state=%0d", state);
  endtask

  task automatic test_reset_midrun();
    press();
    repeat (5) tick();
    checks++;
    if (run !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: run=%0b, expected 1", run);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (run !== 1'b0 || state !== 2'd0 || cycle_count !== 32'd0 || complete !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL midreset: run=%0b state=%0d count=%0d complete=%0b timeout=%0b, expected all 0",
                        run, state, cycle_count, complete, timeout);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    $display("reset_midrun: run=%0b state=%0d", run, state);
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_bounce();
    test_timeout();
    test_stale_done();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
